// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit positions and state encoding for the
// decode->execute pipeline register.
package pipe_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int CTRL_W   = 16;
  localparam int LOAD_BIT = 0;

  // Bit positions inside the opaque decoder control bundle
  localparam int CTRL_LOAD_BIT   = LOAD_BIT;
  localparam int CTRL_STORE_BIT  = 1;
  localparam int CTRL_BRANCH_BIT = 2;
  localparam int CTRL_JUMP_BIT   = 3;
  localparam int CTRL_REGW_BIT   = 4;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } pipe_state_e;

  function automatic logic is_load(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_LOAD_BIT];
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Selects write-back data over register-file data when the write-back
// targets the same nonzero register; x0 always passes through untouched.
module operand_bypass
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   rfdata,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  output logic [XLEN-1:0]   data
);

  // Operand select between register file and write-back port
  always_comb begin
    data = rfdata;
    if (wb_we && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == addr)) begin
      data = wb_wd;
    end else begin
      data = rfdata;
    end
  end

endmodule

// File: rtl/decode_execute_pipe.sv
// Single-entry decode->execute pipeline register with write-back bypass,
// load-use hazard detection, valid/ready flow control and flush.
module decode_execute_pipe
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_rd1,
  input  logic [XLEN-1:0]   in_rd2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              hazard,
  output logic [31:0]       stall_cnt
);

  pipe_state_e       state;
  pipe_state_e       state_next;
  logic [REG_AW-1:0] held_rs1;
  logic [REG_AW-1:0] held_rs2;
  logic              accept;
  logic              drain;
  logic [XLEN-1:0]   cap_op1;
  logic [XLEN-1:0]   cap_op2;
  logic [XLEN-1:0]   ref_op1;
  logic [XLEN-1:0]   ref_op2;

  operand_bypass u_cap_op1 (
    .addr(in_rs1), .rfdata(in_rd1), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .data(cap_op1)
  );
  operand_bypass u_cap_op2 (
    .addr(in_rs2), .rfdata(in_rd2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .data(cap_op2)
  );
  // Refresh path keeps a stalled entry's operands in step with the register file
  operand_bypass u_ref_op1 (
    .addr(held_rs1), .rfdata(out_op1), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .data(ref_op1)
  );
  operand_bypass u_ref_op2 (
    .addr(held_rs2), .rfdata(out_op2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .data(ref_op2)
  );

  assign out_valid = (state == ST_FULL);
  assign hazard    = out_valid && is_load(out_ctrl) && (out_rd != {REG_AW{1'b0}}) &&
                     ((out_rd == in_rs1) || (out_rd == in_rs2)) && in_valid;
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Next-state selection, flush dominating accept dominating drain
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (!flush && accept) state_next = ST_FULL;
        else                  state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (flush)       state_next = ST_EMPTY;
        else if (accept) state_next = ST_FULL;
        else if (drain)  state_next = ST_EMPTY;
        else             state_next = ST_FULL;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  // Entry payload: capture on accept, otherwise refresh operands while held
  always_ff @(posedge clk) begin
    if (rst) begin
      out_op1  <= {XLEN{1'b0}};
      out_op2  <= {XLEN{1'b0}};
      out_imm  <= {XLEN{1'b0}};
      out_pc   <= {XLEN{1'b0}};
      out_rd   <= {REG_AW{1'b0}};
      out_ctrl <= {CTRL_W{1'b0}};
      held_rs1 <= {REG_AW{1'b0}};
      held_rs2 <= {REG_AW{1'b0}};
    end else if (accept && !flush) begin
      out_op1  <= cap_op1;
      out_op2  <= cap_op2;
      out_imm  <= in_imm;
      out_pc   <= in_pc;
      out_rd   <= in_rd;
      out_ctrl <= in_ctrl;
      held_rs1 <= in_rs1;
      held_rs2 <= in_rs2;
    end else if (out_valid && !drain) begin
      out_op1 <= ref_op1;
      out_op2 <= ref_op2;
    end
  end

  // Saturating load-use stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
